// File: rtl/ins_prefetch_unit_if.sv
// Fetch-side bus of the instruction prefetch unit: ROM port, core instruction
// handshake, and redirect/halt controls. master = prefetch unit, slave = ROM + core.
interface ins_prefetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int INS_W  = 8,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [INS_W-1:0]  rom_data;
    logic              ins_valid;
    logic [INS_W-1:0]  ins_data;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              halt;
    logic              halted;
    logic [LVL_W-1:0]  level;

    modport master (
        output rom_addr, rom_en, ins_valid, ins_data, ins_pc, halted, level,
        input  rom_data, ins_ready, redirect, redirect_addr, halt
    );

    modport slave (
        input  rom_addr, rom_en, ins_valid, ins_data, ins_pc, halted, level,
        output rom_data, ins_ready, redirect, redirect_addr, halt
    );
endinterface

// File: rtl/ins_prefetch_unit.sv
// Instruction prefetch stage: credit-limited ROM reads into a small FIFO of
// {instruction, pc} entries, with epoch-tagged flush on redirect and sticky halt.
module ins_prefetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INS_W    = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                rstn,
    ins_prefetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INS_W-1:0]  data;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_en_q, rom_en_d;
    logic              tag_q, tag_d;
    logic              epoch_q, epoch_d;
    logic              halted_q, halted_d;

    logic ins_valid, pop, push, take_halt, take_redir, can_issue;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign ins_valid = (level_q != '0) && !halted_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        fpc_d      = fpc_q;
        rom_addr_d = rom_addr_q;
        rom_en_d   = 1'b0;
        tag_d      = tag_q;
        epoch_d    = epoch_q;
        halted_d   = halted_q;

        // Halt beats redirect; a handshake in the same cycle still completes.
        pop        = ins_valid && bus.ins_ready;
        take_halt  = !halted_q && bus.halt;
        take_redir = !halted_q && !bus.halt && bus.redirect;
        push       = rom_en_q && (tag_q == epoch_q) && !halted_q && !bus.halt && !bus.redirect;
        can_issue  = !halted_q && !bus.halt && !bus.redirect
                     && ((level_q + LVL_W'(rom_en_q)) < LVL_W'(DEPTH));

        if (take_redir) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
            epoch_d  = !epoch_q;
            fpc_d    = bus.redirect_addr;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end

        if (take_halt) halted_d = 1'b1;

        if (can_issue) begin
            rom_en_d   = 1'b1;
            rom_addr_d = fpc_q;
            fpc_d      = fpc_q + ADDR_W'(1);
            tag_d      = epoch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: the FIFO storage is reset too so ins_data/ins_pc read 0 out of reset rather than X.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            fpc_q      <= RESET_PC;
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
            tag_q      <= 1'b0;
            epoch_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= entry_t'{data: bus.rom_data, pc: rom_addr_q};
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            fpc_q      <= fpc_d;
            rom_addr_q <= rom_addr_d;
            rom_en_q   <= rom_en_d;
            tag_q      <= tag_d;
            epoch_q    <= epoch_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_en    = rom_en_q;
    assign bus.ins_valid = ins_valid;
    assign bus.ins_data  = mem_q[rd_ptr_q].data;
    assign bus.ins_pc    = mem_q[rd_ptr_q].pc;
    assign bus.halted    = halted_q;
    assign bus.level     = level_q;
endmodule

// File: tb/tb_ins_prefetch_unit.sv
// Bench for ins_prefetch_unit: directed vector table, hand sequences for the
// multi-cycle corners, and a randomized run against a queue-based model.
module tb_ins_prefetch_unit;
    localparam int DEPTH_A = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a, rstn_b;

    ins_prefetch_unit_if #(.ADDR_W(8), .INS_W(8), .DEPTH(DEPTH_A)) bus_a ();
    ins_prefetch_unit_if #(.ADDR_W(8), .INS_W(8), .DEPTH(2))       bus_b ();

    ins_prefetch_unit #(.ADDR_W(8), .INS_W(8), .DEPTH(DEPTH_A), .RESET_PC(8'h00)) dut_a (
        .clk(clk), .rstn(rstn_a), .bus(bus_a.master)
    );
    ins_prefetch_unit #(.ADDR_W(8), .INS_W(8), .DEPTH(2), .RESET_PC(8'hFE)) dut_b (
        .clk(clk), .rstn(rstn_b), .bus(bus_b.master)
    );

    // ROM image: ROM[i] = i + 0x10, returned in the cycle the read is outstanding.
    function automatic logic [7:0] rom_val(input logic [7:0] a);
        return a + 8'h10;
    endfunction

    assign bus_a.rom_data = rom_val(bus_a.rom_addr);
    assign bus_b.rom_data = rom_val(bus_b.rom_addr);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic rdy, input logic rd, input logic [7:0] ra, input logic h);
        bus_a.ins_ready     = rdy;
        bus_a.redirect      = rd;
        bus_a.redirect_addr = ra;
        bus_a.halt          = h;
    endtask

    // Holds reset over two edges, checks the reset state, releases at a falling edge.
    task automatic reset_a(input string tag);
        rstn_a = 1'b0;
        drive_a(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        check({tag, "_rst_en"},     32'(bus_a.rom_en),    0);
        check({tag, "_rst_addr"},   32'(bus_a.rom_addr),  0);
        check({tag, "_rst_valid"},  32'(bus_a.ins_valid), 0);
        check({tag, "_rst_pc"},     32'(bus_a.ins_pc),    0);
        check({tag, "_rst_data"},   32'(bus_a.ins_data),  0);
        check({tag, "_rst_halted"}, 32'(bus_a.halted),    0);
        check({tag, "_rst_level"},  32'(bus_a.level),     0);
        rstn_a = 1'b1;
    endtask

    typedef struct {
        logic       rdy;
        logic       rd;
        logic [7:0] ra;
        logic       h;
        logic       e_valid;
        logic [7:0] e_pc;
        logic [2:0] e_level;
        logic       e_en;
        logic [7:0] e_addr;
        logic       e_halted;
    } vec_t;

    vec_t tbl [16];

    // Reference model: FIFO of pcs, fetch pointer, one outstanding read.
    logic [7:0] mq[$];
    logic [7:0] m_fpc, m_paddr;
    bit         m_pend, m_halted;

    task automatic model_reset();
        mq.delete();
        m_fpc    = 8'h00;
        m_paddr  = 8'h00;
        m_pend   = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic model_edge(input bit rdy, input bit rd, input logic [7:0] ra, input bit h);
        int lvl0;
        bit was_pend, can;
        if (m_halted) return;
        lvl0     = mq.size();
        was_pend = m_pend;
        can      = (lvl0 + int'(was_pend)) < DEPTH_A;
        if (rdy && lvl0 > 0) void'(mq.pop_front());
        if (h) begin
            m_halted = 1'b1;
            m_pend   = 1'b0;
        end else if (rd) begin
            mq.delete();
            m_pend = 1'b0;
            m_fpc  = ra;
        end else begin
            if (was_pend) mq.push_back(m_paddr);
            m_pend = can;
            if (can) begin
                m_paddr = m_fpc;
                m_fpc   = m_fpc + 8'h01;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] got_pc[$];
        logic [7:0] got_data[$];
        logic [7:0] exp_b [4];

        rstn_b = 1'b0;
        bus_b.ins_ready = 1'b0; bus_b.redirect = 1'b0;
        bus_b.redirect_addr = 8'h00; bus_b.halt = 1'b0;

        // Backpressure to credit limit, release, redirect with a read in flight, then halt.
        //             rdy rd  ra     h   val pc     lvl   en  addr   hlt
        tbl[0]  = '{1'b0,1'b0,8'h00,1'b0, 1'b0,8'h00,3'd0, 1'b1,8'h00,1'b0};
        tbl[1]  = '{1'b0,1'b0,8'h00,1'b0, 1'b1,8'h00,3'd1, 1'b1,8'h01,1'b0};
        tbl[2]  = '{1'b0,1'b0,8'h00,1'b0, 1'b1,8'h00,3'd2, 1'b1,8'h02,1'b0};
        tbl[3]  = '{1'b0,1'b0,8'h00,1'b0, 1'b1,8'h00,3'd3, 1'b1,8'h03,1'b0};
        tbl[4]  = '{1'b0,1'b0,8'h00,1'b0, 1'b1,8'h00,3'd4, 1'b0,8'h00,1'b0};
        tbl[5]  = '{1'b0,1'b0,8'h00,1'b0, 1'b1,8'h00,3'd4, 1'b0,8'h00,1'b0};
        tbl[6]  = '{1'b1,1'b0,8'h00,1'b0, 1'b1,8'h01,3'd3, 1'b0,8'h00,1'b0};
        tbl[7]  = '{1'b1,1'b0,8'h00,1'b0, 1'b1,8'h02,3'd2, 1'b1,8'h04,1'b0};
        tbl[8]  = '{1'b0,1'b0,8'h00,1'b0, 1'b1,8'h02,3'd3, 1'b1,8'h05,1'b0};
        tbl[9]  = '{1'b1,1'b1,8'h80,1'b0, 1'b0,8'h00,3'd0, 1'b0,8'h00,1'b0};
        tbl[10] = '{1'b1,1'b0,8'h00,1'b0, 1'b0,8'h00,3'd0, 1'b1,8'h80,1'b0};
        tbl[11] = '{1'b1,1'b0,8'h00,1'b0, 1'b1,8'h80,3'd1, 1'b1,8'h81,1'b0};
        tbl[12] = '{1'b1,1'b0,8'h00,1'b0, 1'b1,8'h81,3'd1, 1'b1,8'h82,1'b0};
        tbl[13] = '{1'b0,1'b0,8'h00,1'b1, 1'b0,8'h00,3'd1, 1'b0,8'h00,1'b1};
        tbl[14] = '{1'b1,1'b1,8'h20,1'b0, 1'b0,8'h00,3'd1, 1'b0,8'h00,1'b1};
        tbl[15] = '{1'b1,1'b0,8'h00,1'b0, 1'b0,8'h00,3'd1, 1'b0,8'h00,1'b1};

        reset_a("tbl");
        for (int i = 0; i < 16; i++) begin
            drive_a(tbl[i].rdy, tbl[i].rd, tbl[i].ra, tbl[i].h);
            @(negedge clk);
            check($sformatf("tbl%0d_valid", i),  32'(bus_a.ins_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_level", i),  32'(bus_a.level),     32'(tbl[i].e_level));
            check($sformatf("tbl%0d_en", i),     32'(bus_a.rom_en),    32'(tbl[i].e_en));
            check($sformatf("tbl%0d_halted", i), 32'(bus_a.halted),    32'(tbl[i].e_halted));
            if (tbl[i].e_en)
                check($sformatf("tbl%0d_addr", i), 32'(bus_a.rom_addr), 32'(tbl[i].e_addr));
            if (tbl[i].e_valid) begin
                check($sformatf("tbl%0d_pc", i),   32'(bus_a.ins_pc),   32'(tbl[i].e_pc));
                check($sformatf("tbl%0d_data", i), 32'(bus_a.ins_data), 32'(rom_val(tbl[i].e_pc)));
            end
        end

        // Streaming with ins_ready held high: first instruction two edges after release, then no gaps.
        reset_a("stream");
        drive_a(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("stream_valid_R", 32'(bus_a.ins_valid), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("stream%0d_valid", k), 32'(bus_a.ins_valid), 1);
            check($sformatf("stream%0d_pc", k),    32'(bus_a.ins_pc),    32'(k));
            check($sformatf("stream%0d_data", k),  32'(bus_a.ins_data),  32'(k + 16));
        end

        // Halt with two entries stored; later redirect is ignored; reset recovers.
        reset_a("halt");
        drive_a(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("halt_pre_level", 32'(bus_a.level), 2);
        drive_a(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("halt_halted", 32'(bus_a.halted),    1);
        check("halt_valid",  32'(bus_a.ins_valid), 0);
        check("halt_en",     32'(bus_a.rom_en),    0);
        check("halt_level",  32'(bus_a.level),     2);
        drive_a(1'b1, 1'b1, 8'h40, 1'b0);
        @(negedge clk);
        drive_a(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("halt_hold%0d_en", k),    32'(bus_a.rom_en),    0);
            check($sformatf("halt_hold%0d_valid", k), 32'(bus_a.ins_valid), 0);
            check($sformatf("halt_hold%0d_level", k), 32'(bus_a.level),     2);
            @(negedge clk);
        end
        reset_a("halt_clear");
        drive_a(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("restart_en",   32'(bus_a.rom_en),   1);
        check("restart_addr", 32'(bus_a.rom_addr), 0);

        // Halt and redirect together: halt wins, no further issue.
        repeat (4) @(negedge clk);
        drive_a(1'b1, 1'b1, 8'h55, 1'b1);
        @(negedge clk);
        drive_a(1'b1, 1'b0, 8'h00, 1'b0);
        check("hr_halted", 32'(bus_a.halted), 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("hr%0d_en", k),    32'(bus_a.rom_en),    0);
            check($sformatf("hr%0d_valid", k), 32'(bus_a.ins_valid), 0);
            @(negedge clk);
        end

        // DEPTH=2 instance starting at 0xFE: address wrap with matching data.
        bus_b.ins_ready = 1'b1;
        repeat (2) @(negedge clk);
        rstn_b = 1'b1;
        for (int c = 0; c < 20 && got_pc.size() < 4; c++) begin
            @(negedge clk);
            if (bus_b.ins_valid && bus_b.ins_ready) begin
                got_pc.push_back(bus_b.ins_pc);
                got_data.push_back(bus_b.ins_data);
            end
        end
        check("wrap_count", 32'(got_pc.size()), 4);
        exp_b = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        for (int k = 0; k < 4; k++) begin
            if (k < got_pc.size()) begin
                check($sformatf("wrap%0d_pc", k),   32'(got_pc[k]),   32'(exp_b[k]));
                check($sformatf("wrap%0d_data", k), 32'(got_data[k]), 32'(rom_val(exp_b[k])));
            end
        end

        // Randomized traffic against the reference model.
        reset_a("rnd");
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit         r_rst, r_rdy, r_rd, r_h;
            logic [7:0] r_ra;
            r_rst = ($urandom_range(0, 199) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rd  = ($urandom_range(0, 19) == 0);
            r_h   = ($urandom_range(0, 399) == 0);
            r_ra  = 8'($urandom);
            if (r_rst) begin
                rstn_a = 1'b0;
                drive_a(1'b0, 1'b0, 8'h00, 1'b0);
                model_reset();
            end else begin
                rstn_a = 1'b1;
                drive_a(r_rdy, r_rd, r_ra, r_h);
                model_edge(r_rdy, r_rd, r_ra, r_h);
            end
            @(negedge clk);
            check("rnd_en",     32'(bus_a.rom_en),    32'(m_pend));
            check("rnd_halted", 32'(bus_a.halted),    32'(m_halted));
            check("rnd_level",  32'(bus_a.level),     32'(mq.size()));
            check("rnd_valid",  32'(bus_a.ins_valid), 32'(mq.size() > 0 && !m_halted));
            if (m_pend) check("rnd_addr", 32'(bus_a.rom_addr), 32'(m_paddr));
            if (mq.size() > 0 && !m_halted) begin
                check("rnd_pc",   32'(bus_a.ins_pc),   32'(mq[0]));
                check("rnd_data", 32'(bus_a.ins_data), 32'(rom_val(mq[0])));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ins_prefetch_unit.md
# ins_prefetch_unit

Parametrised instruction-fetch stage between the instruction ROM and the processor core. It replaces the direct ROM-to-core address/instruction wiring of earlier processor tops. It keeps a small prefetch FIFO of instructions tagged with their addresses so the core can consume one instruction per cycle. It also supports jump redirects with flush, and halts fetching on end-of-process.

## Interface
- ADDR_W, 8, instruction address width (ROM depth 2^ADDR_W)
- INS_W, 8, instruction word width
- DEPTH, 4, prefetch FIFO entries; legal range 2..16
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- rom_addr  out  ADDR_W  ROM read address (registered)
- rom_en  out  1  ROM read strobe (registered); data returns exactly 1 cycle later
- rom_data  in  INS_W  ROM read data, valid in the cycle after rom_en=1
- ins_valid  out  1  head FIFO entry presented to core
- ins_data  out  INS_W  head instruction
- ins_pc  out  ADDR_W  address of head instruction
- ins_ready  in  1  core accepts head this cycle (handshake = ins_valid & ins_ready)
- redirect  in  1  jump taken; flush and refetch from redirect_addr
- redirect_addr  in  ADDR_W  jump target
- halt  in  1  end-of-process from core
- halted  out  1  fetch stopped, sticky until reset
- level  out  log2(DEPTH)+1  stored FIFO entries

## Operation
- Reset (rstn=0 at an edge) sets:
  - rom_en=0, rom_addr=0, ins_valid=0, ins_data=0, ins_pc=0, halted=0, level=0.
  - Fetch pointer = RESET_PC; in-flight flag = 0; epoch = 0.
- Issue rule:
  - In a cycle where halted=0 and level + inflight < DEPTH (registered values), the next edge sets rom_en=1 and rom_addr=fpc, and sets fpc=fpc+1.
  - Otherwise rom_en=0.
- fpc arithmetic is modulo 2^ADDR_W: address 2^ADDR_W-1 wraps to 0 with no flag.
- Return: a read issued with rom_en=1 is pushed into the FIFO as {rom_data, its address} at the following edge, if its epoch tag equals the current epoch. Otherwise it is discarded.
- Pop: occurs at an edge where ins_valid=1 and ins_ready=1. ins_valid = (level>0) & ~halted.
- Push and pop may occur at the same edge; level is unchanged in that case.
- Overflow is impossible by the credit rule.
- Redirect (redirect=1, halted=0):
  - A handshake in the same cycle completes; the core owns the jump instruction.
  - At that edge: FIFO cleared (level=0), any in-flight return discarded via epoch toggle, fpc=redirect_addr.
  - Issue from redirect_addr follows the normal rule next cycle.
  - Redirect is ignored while halted=1.
- Halt:
  - At the edge where halt=1, halted goes 1 and stays until reset.
  - rom_en drops to 0 at that edge; no further issue.
  - ins_valid forced 0; FIFO contents frozen and not popped.
  - halt and redirect in the same cycle: halt wins and the redirect is ignored.
- Reset mid-operation discards FIFO, in-flight read and halted state; fetch restarts at RESET_PC.

## Timing
- Edge R is the first edge with rstn=1.
- Reset-to-first-instruction:
  - rom_en=1, rom_addr=RESET_PC after edge R.
  - Push at R+1; ins_valid=1 after R+1.
- Redirect sampled at edge E:
  - rom_en with target address after E+1.
  - Target instruction valid after E+2.
  - Bubble of 2 cycles.
- Sustained throughput is 1 instruction/cycle when DEPTH≥3 and ins_ready is held high. With DEPTH=2 it alternates 1 every 2 cycles.
- Backpressure: with ins_ready=0, issue continues until level + inflight = DEPTH, then rom_en=0. Issue resumes the cycle after a pop lowers the count.
- All outputs are registered; no combinational path from ins_ready, redirect or halt to rom_en/rom_addr.

## Test plan
- Reset release, ROM[i]=i+0x10, ins_ready=1, DEPTH=4:
  - ins_valid rises 2 cycles after rstn high.
  - Core sees pc 0,1,2,… with data 0x10,0x11,… one per cycle, no gaps.
- ins_ready=0 for 10 cycles after start:
  - rom_en stops after 4 issues; level=4; ins_pc/ins_data held at 0/0x10.
  - Release: data 0x10..0x13 delivered, then fetch resumes at pc 4.
- Redirect to 0x80 while level=3 and a read is in flight:
  - Stale data never appears.
  - Next ins_pc=0x80 exactly 2 cycles after the redirect edge; level=0 immediately after.
- ADDR_W=8, RESET_PC=0xFE:
  - Delivered pcs 0xFE, 0xFF, 0x00, 0x01 with matching ROM data.
- halt asserted while level=2:
  - halted=1 and ins_valid=0 next cycle; rom_en stays 0.
  - A subsequent redirect is ignored.
  - rstn=0 clears halted and level; fetch restarts at RESET_PC.
- halt and redirect in the same cycle: halted=1, fpc not reloaded, no rom_en afterwards.
